// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus arbitration interface: request lines in, one-hot grant and
// grant/timeout status out. "master" is the requester side, "slave" the arbiter.
interface bus_arbiter_rr_if #(
   parameter int NUM_MASTERS = 8,
   parameter int ID_WIDTH    = 3
);

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] master_ack;
   logic                   grant_valid;
   logic [ID_WIDTH-1:0]    grant_id;
   logic                   timeout;
   logic [ID_WIDTH-1:0]    timeout_id;

   modport master (
      output req,
      input  master_ack,
      input  grant_valid,
      input  grant_id,
      input  timeout,
      input  timeout_id
   );

   modport slave (
      input  req,
      output master_ack,
      output grant_valid,
      output grant_id,
      output timeout,
      output timeout_id
   );

endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: IDLE -> GRANT -> RELEASE tenures, one-hot ack.
// Define BUS_ARB_TIMEOUT_EN to force release after MAX_TENURE cycles.
module bus_arbiter_rr #(
   parameter int NUM_MASTERS = 8,
   parameter int ID_WIDTH    = 3,
   parameter int MAX_TENURE  = 256,
   parameter int CNT_WIDTH   = 9
) (
   input logic              clk,
   input logic              reset_L,
   bus_arbiter_rr_if.slave  bus
);

   if (NUM_MASTERS > (1 << ID_WIDTH)) begin : g_bad_id_width
      $error("ID_WIDTH cannot encode NUM_MASTERS");
   end
   if (MAX_TENURE > (1 << CNT_WIDTH)) begin : g_bad_cnt_width
      $error("CNT_WIDTH cannot hold MAX_TENURE");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [ID_WIDTH:0]   NM   = (ID_WIDTH+1)'(NUM_MASTERS);
   localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_MASTERS - 1);

   state_t                 state;
   logic [NUM_MASTERS-1:0] ack_q;
   logic                   valid_q;
   logic [ID_WIDTH-1:0]    id_q;
   logic [ID_WIDTH-1:0]    ptr;
   logic [ID_WIDTH-1:0]    ptr_next;

   logic                   win_found;
   logic [ID_WIDTH-1:0]    win_id;
   logic [ID_WIDTH:0]      sum;

   // Rotating priority search starting at ptr, wrapping at NUM_MASTERS.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      sum       = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         sum = {1'b0, ptr} + (ID_WIDTH+1)'(i);
         if (sum >= NM) begin
            sum = sum - NM;
         end
         if (!win_found && bus.req[sum[ID_WIDTH-1:0]]) begin
            win_found = 1'b1;
            win_id    = sum[ID_WIDTH-1:0];
         end
      end
   end

   assign ptr_next = (id_q == LAST) ? '0 : id_q + 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_TENURE - 1);

   logic [CNT_WIDTH-1:0] cnt;
   logic                 to_q;
   logic [ID_WIDTH-1:0]  to_id_q;

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state   <= IDLE;
         ack_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         ptr     <= '0;
         cnt     <= '0;
         to_q    <= 1'b0;
         to_id_q <= '0;
      end else begin
         to_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (win_found) begin
                  state   <= GRANT;
                  ack_q   <= NUM_MASTERS'(1) << win_id;
                  valid_q <= 1'b1;
                  id_q    <= win_id;
                  cnt     <= '0;
               end
            end
            GRANT: begin
               if (!bus.req[id_q]) begin
                  state   <= RELEASE;
                  ack_q   <= '0;
                  valid_q <= 1'b0;
                  id_q    <= '0;
                  ptr     <= ptr_next;
               end else if (cnt == CNT_LAST) begin
                  state   <= RELEASE;
                  ack_q   <= '0;
                  valid_q <= 1'b0;
                  id_q    <= '0;
                  ptr     <= ptr_next;
                  to_q    <= 1'b1;
                  to_id_q <= id_q;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.timeout    = to_q;
   assign bus.timeout_id = to_id_q;
`else
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state   <= IDLE;
         ack_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         ptr     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (win_found) begin
                  state   <= GRANT;
                  ack_q   <= NUM_MASTERS'(1) << win_id;
                  valid_q <= 1'b1;
                  id_q    <= win_id;
               end
            end
            GRANT: begin
               // No preemption: only the owner's request ends a tenure.
               if (!bus.req[id_q]) begin
                  state   <= RELEASE;
                  ack_q   <= '0;
                  valid_q <= 1'b0;
                  id_q    <= '0;
                  ptr     <= ptr_next;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.timeout    = 1'b0;
   assign bus.timeout_id = '0;
`endif

   assign bus.master_ack  = ack_q;
   assign bus.grant_valid = valid_q;
   assign bus.grant_id    = id_q;

endmodule
